// File: rtl/cla_nibble_seq_adder_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
// Holds the controller state encoding, the nibble width and the overflow rule.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIBBLE_W = 4;

    // Two's-complement overflow: same-signed operands produced a differently signed result.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_nibble_seq_adder_cla4.sv
// Purely combinational 4-bit carry-lookahead adder.
// Every carry is expanded from generate/propagate terms, so no carry ripples between bits.
module cla4_comb
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] r,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign r    = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// WIDTH-bit add/subtract built from one 4-bit CLA, run one nibble per cycle, LSB nibble first.
// Handshake: start accepted in IDLE or DONE, busy during the passes, done pulses once with the result.
module cla_nibble_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // WIDTH must be a multiple of 4 and at least 8, so NIB >= 2 and CNT_W >= 1.
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   work;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_r;
    logic                nib_c;

    assign nib_a = op_a[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = op_b[int'(cnt)*NIBBLE_W +: NIBBLE_W];

    cla4_comb u_cla (
        .x    (nib_a),
        .y    (nib_b),
        .cin  (carry),
        .r    (nib_r),
        .cout (nib_c)
    );

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples pre-edge values; blocking here would let later lines see this cycle's writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: working registers are cleared too, not just the visible outputs, so an
            // abandoned operation leaves no stale operands or carry behind.
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B here and force the carry-in.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                RUN: begin
                    work[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= nib_r;
                    carry <= nib_c;
                    if (cnt == LAST) begin
                        // Final nibble comes straight from the adder; earlier ones from work.
                        sum   <= {nib_r, work[WIDTH-NIBBLE_W-1:0]};
                        cout  <= nib_c;
                        ovf   <= signed_ovf(op_a[WIDTH-1], op_b[WIDTH-1], nib_r[NIBBLE_W-1]);
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench for cla_nibble_seq_adder (WIDTH=16): fixed vectors, nibble sweep,
// random operations against an integer-arithmetic model, and handshake corner sequences.
module tb_cla_nibble_seq_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_nibble_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    typedef struct {
        string            name;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vsub;
        logic             vcin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model in plain integer arithmetic: signed range for overflow, a >= b for no-borrow.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         input logic msub, input logic mcin,
                         output logic [WIDTH-1:0] ms, output logic mc, output logic mo);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            sr = sa - sb;
            mc = (ua >= ub);
        end else begin
            ur = ua + ub + int'(mcin);
            sr = sa + sb + int'(mcin);
            mc = (ur > 65535);
        end
        ms = ur[WIDTH-1:0];
        mo = (sr > 32767) || (sr < -32768);
    endtask

    // Called at the negedge after the accepting edge; stops at the done cycle or after a bound.
    task automatic wait_done(input logic [WIDTH-1:0] prev, output int busy_cycles,
                             output bit seen, output bit stable);
        busy_cycles = 0;
        seen        = 1'b0;
        stable      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (sum !== prev) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic ts, input logic tc,
                          output logic [WIDTH-1:0] rs, output logic rc, output logic ro);
        logic [WIDTH-1:0] prev;
        int  cyc;
        bit  seen;
        bit  stable;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        prev = sum;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        wait_done(prev, cyc, seen, stable);
        check({name, ".done_seen"}, 32'(seen), 32'd1);
        check({name, ".busy_cycles"}, 32'(cyc), 32'(NIB));
        check({name, ".held_while_busy"}, 32'(stable), 32'd1);
        check({name, ".busy_at_done"}, 32'(busy), 32'd0);
        rs = sum; rc = cout; ro = ovf;
        @(negedge clk);
        check({name, ".done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] gs, ms, ta, tbv;
        logic gc, go, mc, mo, ts, tc;
        int  cyc;
        bit  seen;
        bit  stable;

        vecs[0] = '{"add_00ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add_7fff_cin", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_5_7",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_1",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"add_8000_8000",16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{"sub_equal",    16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.sum",  32'(sum),  32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset.ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin, gs, gc, go);
            check({vecs[i].name, ".sum"},  32'(gs), 32'(vecs[i].exp_sum));
            check({vecs[i].name, ".cout"}, 32'(gc), 32'(vecs[i].exp_cout));
            check({vecs[i].name, ".ovf"},  32'(go), 32'(vecs[i].exp_ovf));
        end

        for (int i = 0; i < 16; i++) begin
            ta = WIDTH'(i * 16'h1111);
            model(ta, ta, 1'b0, 1'b1, ms, mc, mo);
            run_op($sformatf("sweep%0d", i), ta, ta, 1'b0, 1'b1, gs, gc, go);
            check($sformatf("sweep%0d.sum", i),  32'(gs), 32'(ms));
            check($sformatf("sweep%0d.cout", i), 32'(gc), 32'(mc));
            check($sformatf("sweep%0d.ovf", i),  32'(go), 32'(mo));
        end

        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom); tbv = WIDTH'($urandom);
            ts = 1'($urandom); tc = 1'($urandom);
            model(ta, tbv, ts, tc, ms, mc, mo);
            run_op($sformatf("rand%0d", i), ta, tbv, ts, tc, gs, gc, go);
            check($sformatf("rand%0d.sum", i),  32'(gs), 32'(ms));
            check($sformatf("rand%0d.cout", i), 32'(gc), 32'(mc));
            check($sformatf("rand%0d.ovf", i),  32'(go), 32'(mo));
        end

        // start held high during RUN with different operands must not disturb the first result.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        ms = sum;
        for (int i = 0; i < NIB - 1; i++) begin
            @(negedge clk);
            a = 16'h1234; b = 16'h4321; sub = 1'b1; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(ms, cyc, seen, stable);
        check("hold_start.done_seen", 32'(seen), 32'd1);
        check("hold_start.sum",  32'(sum),  32'h0100);
        check("hold_start.cout", 32'(cout), 32'd0);
        @(negedge clk);
        check("hold_start.no_requeue", 32'(busy), 32'd0);

        // Reset two edges into an operation: everything clears and no done follows.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h7FFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midreset.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.sum",  32'(sum),  32'd0);
        check("midreset.cout", 32'(cout), 32'd0);
        check("midreset.ovf",  32'(ovf),  32'd0);
        seen = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midreset.no_done", 32'(seen), 32'd0);
        model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, ms, mc, mo);
        run_op("after_reset", 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, gs, gc, go);
        check("after_reset.sum",  32'(gs), 32'(ms));
        check("after_reset.cout", 32'(gc), 32'(mc));

        // Back-to-back: new start in the DONE cycle.
        @(negedge clk);
        a = 16'h1000; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        ms = sum;
        @(negedge clk);
        start = 1'b0;
        wait_done(ms, cyc, seen, stable);
        check("b2b.first_done", 32'(seen), 32'd1);
        check("b2b.first_sum",  32'(sum),  32'h1001);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy_next", 32'(busy), 32'd1);
        check("b2b.done_drop", 32'(done), 32'd0);
        check("b2b.first_held", 32'(sum), 32'h1001);
        wait_done(16'h1001, cyc, seen, stable);
        check("b2b.second_done", 32'(seen), 32'd1);
        check("b2b.second_cycles", 32'(cyc), 32'(NIB));
        check("b2b.second_sum", 32'(sum), 32'h2345);
        check("b2b.second_cout", 32'(cout), 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one 4-bit carry-lookahead adder nibble by nibble, LSB nibble first, chaining carry between passes. Start/busy/done handshake toward the requesting datapath. Registered operand capture, working registers and result registers. Sits between the lab ALU datapath and the 4-bit CLA, so wide operands reuse one small adder.

Parameters:
WIDTH, 16, operand/result width; multiple of 4, minimum 8
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
sub  in  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored)
cin  in  1  carry-in for add
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
busy  out  1  high while nibbles are being processed
done  out  1  one-cycle pulse: result valid
sum  out  WIDTH  result register, held until next completion
cout  out  1  final carry-out (for sub: 1 = no borrow)
ovf  out  1  signed overflow of the completed operation

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy, done, cout, ovf = 0; sum = 0; working registers and nibble counter cleared. Applies mid-operation: operation abandoned, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> capture A=a, B=(sub ? ~b : b), C=(sub ? 1 : cin), cnt=0, go RUN. start=0 -> stay.
- RUN: at each edge, nibble cnt: {c_out, s} = A[cnt]+B[cnt]+C via CLA; write s into working sum nibble cnt; C <= c_out; cnt++. At edge where cnt==NIB-1: load sum, cout = final carry, ovf = (A_msb==B_msb) && (s_msb!=A_msb), go DONE. start ignored in RUN (no queueing).
- Latency: start at edge k -> busy=1 after edges k..k+NIB-1 (NIB cycles); done=1 after edge k+NIB for exactly one cycle; sum/cout/ovf valid from that cycle on.
- DONE: done=1, busy=0. Next edge: start=1 -> accepted as in IDLE (back-to-back, busy goes high immediately, done drops); else IDLE.
- sum, cout, ovf change only at completion or reset; never show partial results.
- Inputs a, b, sub, cin are don't-care except at the accepting edge.
- cnt is ceil(log2(NIB)) bits; no wrap beyond NIB-1 is possible.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.

Decomposition:
- Package cla_seq_pkg: state enum (IDLE, RUN, DONE), NIBBLE_W=4 constant, overflow helper function.
- Sub-module cla4_comb: purely combinational 4-bit carry-lookahead adder (x, y, cin -> r, cout) using generate/propagate terms. Instantiated once; controller holds all state.

Test Plan:
WIDTH=16 (NIB=4) unless stated
1. a=0x00FF, b=0x0001, cin=0, sub=0, start at edge k -> busy high after k..k+3; done pulse after k+4 only; sum=0x0100, cout=0, ovf=0.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
3. sub=1, cin=1 (ignored): a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Exhaustive-nibble sweep: a=b=i*0x1111 for i=0..15, cin=1 -> sum == (a+b+1) mod 2^16, cout == carry of 17-bit sum, each compared against a reference model.
5. start held high during RUN with new operands -> ignored, first result unchanged. rst=1 at edge k+2 -> all outputs 0, no done pulse; new start afterwards completes correctly.
6. Back-to-back: start=1 in the DONE cycle with a=0x1234, b=0x1111 -> first result visible with done, busy high next cycle, second done exactly NIB cycles later with sum=0x2345.
